// File: rtl/ir_prefetch_queue_pkg.sv
// ir_pkg: instruction field positions, the decoded-field struct and the
// decode function shared by the prefetch queue and the execute stage.
package ir_pkg;

  localparam int INST_W = 18;
  localparam int OP_W   = 7;
  localparam int REG_W  = 3;
  localparam int IMM_W  = 8;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 3;

  // Opcode sits in the top OP_W bits; rd overlaps the low opcode bits,
  // rs and rs2 follow directly below it.
  localparam int OP_LSB  = INST_W - OP_W;
  localparam int RD_LSB  = OP_LSB;
  localparam int RS_LSB  = RD_LSB - REG_W;
  localparam int RS2_LSB = RS_LSB - REG_W;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [INST_W-1:0] func;
    logic [ADDR_W-1:0] addr;
    logic [IMM_W-1:0]  disp;
    logic [IMM_W-1:0]  offset;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rs2;
    logic [IMM_W-1:0]  immed;
    logic [CNT_W-1:0]  count;
  } dec_t;

  // Split a raw instruction into every field view; execute picks the ones
  // its opcode needs.
  function automatic dec_t decode(input logic [INST_W-1:0] inst);
    dec_t d;
    d.op     = inst[INST_W-1 -: OP_W];
    d.func   = inst;
    d.addr   = inst[ADDR_W-1:0];
    d.disp   = inst[IMM_W-1:0];
    d.offset = inst[IMM_W-1:0];
    d.rd     = inst[RD_LSB +: REG_W];
    d.rs     = inst[RS_LSB +: REG_W];
    d.rs2    = inst[RS2_LSB +: REG_W];
    d.immed  = inst[IMM_W-1:0];
    d.count  = inst[CNT_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/ir_prefetch_queue_if.sv
// Fetch-side and execute-side handshake bundle of the prefetch queue.
//
// Handshake rule (both sides): a transfer happens at a rising edge where
// valid and ready are both 1. A producer holding valid=1 keeps its data
// stable until the transfer; ready may depend on state only, never on the
// same-cycle valid.
interface ir_prefetch_queue_if
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [INST_W-1:0]            inst_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  dec_t                         dec_o;
  logic [$clog2(DEPTH+1)-1:0]   level_o;

  // Fetch + execute side driving the queue.
  modport master (
    output in_valid_i, inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, dec_o, level_o
  );

  // The queue itself.
  modport slave (
    input  in_valid_i, inst_i, out_ready_i,
    output in_ready_o, out_valid_o, dec_o, level_o
  );

endinterface

// File: rtl/ir_prefetch_queue_fifo.sv
// ir_fifo: DEPTH x W storage with wrap-bit pointers. Full and empty are
// told apart by the extra pointer MSB; level is the pointer difference.
module ir_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = LW'(wr_ptr - rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; flush returns both pointers to zero and drops the cycle's push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: fetch pushes raw instructions into a DEPTH-entry queue;
// the head is decoded into a registered dec_o with a valid/ready handshake
// toward execute. Field widths come from ir_pkg.
// Build option: define IR_BYPASS_EN to let a push into an empty queue load
// the output register directly (1-edge latency instead of 2).
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  ir_prefetch_queue_if.slave   bus
);

  localparam int LW = $clog2(DEPTH+1);

  logic [INST_W-1:0] head;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              load_ok;
  logic              do_push;
  logic              do_load;
  logic              do_byp;
  logic              q_push;
  logic              out_valid_q;
  dec_t              dec_q;

  ir_fifo #(
    .W     (INST_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_i),
    .push  (q_push),
    .pop   (do_load),
    .din   (bus.inst_i),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready_o  = !full;
  assign bus.level_o     = level;
  assign bus.out_valid_o = out_valid_q;
  assign bus.dec_o       = dec_q;

  // Transfer decisions for this cycle; flush cancels every push and pop.
  always_comb begin
    load_ok = !out_valid_q || bus.out_ready_i;
    do_push = bus.in_valid_i && !full && !flush_i;
    do_load = load_ok && !empty && !flush_i;
`ifdef IR_BYPASS_EN
    do_byp  = do_push && empty && load_ok;
`else
    do_byp  = 1'b0;
`endif
    q_push  = do_push && !do_byp;
  end

  // Output register: load from queue head (or bypass), drop valid when
  // consumed with nothing behind it, hold while execute stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (do_load) begin
      out_valid_q <= 1'b1;
      dec_q       <= decode(head);
    end else if (do_byp) begin
      out_valid_q <= 1'b1;
      dec_q       <= decode(bus.inst_i);
    end else if (load_ok) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios plus random traffic.
// Accepted pushes feed an expected queue; a negedge monitor pops it on
// every output transfer and checks occupancy against a counting model.
module tb_ir_prefetch_queue;
  import ir_pkg::*;

  localparam int DEPTH = 4;

  logic clk_i;
  logic rst_ni;
  logic flush_i;
  bit   rand_rdy;

  int n_checks;
  int n_fail;

  // Reference model state: queue occupancy and output-register valid.
  int   m_lvl;
  bit   m_ov;
  dec_t exp_q[$];

  ir_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  ir_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .bus     (bus)
  );

  // Clock and watchdog.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Field extraction from the documented bit map, using plain arithmetic.
  function automatic dec_t ref_decode(input logic [17:0] x);
    dec_t d;
    d.op     = 7'(x >> 11);
    d.func   = x;
    d.addr   = 12'(x % 4096);
    d.disp   = 8'(x % 256);
    d.offset = 8'(x % 256);
    d.immed  = 8'(x % 256);
    d.rd     = 3'((x >> 11) % 8);
    d.rs     = 3'((x >> 8) % 8);
    d.rs2    = 3'((x >> 5) % 8);
    d.count  = 3'(x % 8);
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_i) begin
    bit   load;
    bit   byp;
    bit   acc;
    bit   ld_ok;
    dec_t e;
    if (!rst_ni) begin
      m_lvl = 0;
      m_ov  = 0;
      exp_q.delete();
    end else begin
      check("level", 128'(bus.level_o), 128'(m_lvl));
      check("out_valid", 128'(bus.out_valid_o), 128'(m_ov));
      check("in_ready", 128'(bus.in_ready_o), 128'(m_lvl != DEPTH));
      if (bus.out_valid_o && bus.out_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'(bus.dec_o.func), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("dec", 128'(bus.dec_o), 128'(e));
        end
      end
      acc = bus.in_valid_i && (m_lvl != DEPTH) && !flush_i;
      if (flush_i) begin
        m_lvl = 0;
        m_ov  = 0;
        exp_q.delete();
      end else begin
        ld_ok = !m_ov || bus.out_ready_i;
        load  = ld_ok && (m_lvl != 0);
`ifdef IR_BYPASS_EN
        byp = acc && (m_lvl == 0) && ld_ok;
`else
        byp = 0;
`endif
        m_lvl = m_lvl + ((acc && !byp) ? 1 : 0) - (load ? 1 : 0);
        if (load || byp) m_ov = 1;
        else if (ld_ok)  m_ov = 0;
        if (acc) exp_q.push_back(ref_decode(bus.inst_i));
      end
    end
  end

  // Driver tasks.
  task automatic push(input logic [17:0] x);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    bus.in_valid_i = 1'b1;
    bus.inst_i     = x;
    do begin
      if (rand_rdy) bus.out_ready_i = 1'($urandom_range(0, 1));
      acc = bus.in_ready_o;
      @(posedge clk_i); #1;
      k++;
    end while (!acc && k < 200);
    bus.in_valid_i = 1'b0;
    check("push_accepted", 128'(acc), 128'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) bus.out_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    rand_rdy = 0;
    bus.out_ready_i = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid_o) && k < 100) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("drain_done", 128'(k < 100), 128'(1));
  endtask

  // Stimulus.
  initial begin
    dec_t d;
    rst_ni          = 1'b0;
    flush_i         = 1'b0;
    rand_rdy        = 0;
    bus.in_valid_i  = 1'b0;
    bus.inst_i      = '0;
    bus.out_ready_i = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("rst_level", 128'(bus.level_o), 128'(0));
    check("rst_dec", 128'(bus.dec_o), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single instruction: latency and field map.
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.inst_i      = 18'h2A5C3;
    @(posedge clk_i); #1;
    bus.in_valid_i  = 1'b0;
`ifndef IR_BYPASS_EN
    check("t1_valid_edge1", 128'(bus.out_valid_o), 128'(0));
    @(posedge clk_i); #1;
`endif
    check("t1_valid", 128'(bus.out_valid_o), 128'(1));
    d = bus.dec_o;
    check("t1_op", 128'(d.op), 128'(7'h54));
    check("t1_rd", 128'(d.rd), 128'(3'h4));
    check("t1_rs", 128'(d.rs), 128'(3'h5));
    check("t1_rs2", 128'(d.rs2), 128'(3'h6));
    check("t1_immed", 128'(d.immed), 128'(8'hC3));
    check("t1_addr", 128'(d.addr), 128'(12'h5C3));
    check("t1_count", 128'(d.count), 128'(3'h3));
    check("t1_func", 128'(d.func), 128'(18'h2A5C3));
    drain();

    // Stall and fill: five pushes, head in dec_o, queue full.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(18'(18'h01000 + i * 18'h00111));
    check("t2_level_full", 128'(bus.level_o), 128'(DEPTH));
    check("t2_in_ready", 128'(bus.in_ready_o), 128'(0));
    check("t2_head", 128'(bus.dec_o.func), 128'(18'h01000));
    drain();

    // Random traffic with random out_ready.
    rand_rdy = 1;
    for (int i = 0; i < 64; i++) begin
      idle($urandom_range(0, 2));
      push(18'($urandom_range(0, 18'h3FFFF)));
    end
    drain();

    // Flush at level 3 together with a push.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(18'(18'h10000 + i));
    check("t4_level3", 128'(bus.level_o), 128'(3));
    flush_i        = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.inst_i     = 18'h3FFFF;
    @(posedge clk_i); #1;
    flush_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    check("t4_level_flush", 128'(bus.level_o), 128'(0));
    check("t4_valid_flush", 128'(bus.out_valid_o), 128'(0));
    bus.out_ready_i = 1'b1;
    push(18'h00ABC);
    push(18'h00DEF);
    drain();

    // Asynchronous reset between edges.
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(18'(18'h20000 + i * 18'h00777));
    #2 rst_ni = 1'b0;
    #1;
    check("t5_valid", 128'(bus.out_valid_o), 128'(0));
    check("t5_level", 128'(bus.level_o), 128'(0));
    check("t5_dec", 128'(bus.dec_o), 128'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Empty-queue push latency.
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.inst_i      = 18'h00001;
    @(posedge clk_i); #1;
    bus.in_valid_i  = 1'b0;
`ifdef IR_BYPASS_EN
    check("t6_valid_edge1", 128'(bus.out_valid_o), 128'(1));
    check("t6_level_edge1", 128'(bus.level_o), 128'(0));
`else
    check("t6_valid_edge1", 128'(bus.out_valid_o), 128'(0));
    check("t6_level_edge1", 128'(bus.level_o), 128'(1));
    @(posedge clk_i); #1;
    check("t6_valid_edge2", 128'(bus.out_valid_o), 128'(1));
`endif
    check("t6_func", 128'(bus.dec_o.func), 128'(18'h00001));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
